// File: rtl/spi_pkg.sv
// Shared types and helpers for the SPI mode-0 slave byte engine.
// Optional macro SPI_BYTE_SYNC_EN (see spi_sync_edge) selects 2-flop pin synchronizers.
package spi_pkg;

   localparam int SPI_BITS = 8;

   typedef logic [2:0] spi_bit_cnt_t;
   typedef logic [7:0] spi_byte_t;

   // MSB-first receive: the newest MOSI bit enters at the LSB.
   function automatic spi_byte_t spi_shift_in(input spi_byte_t cur, input logic bit_i);
      return {cur[6:0], bit_i};
   endfunction

endpackage

// File: rtl/spi_byte_core_if.sv
// Pin and byte-level signals of the SPI slave byte engine, grouped for the core and its peer.
interface spi_byte_core_if;
   import spi_pkg::*;

   logic      spi_sclk_i;
   logic      spi_cs_ni;
   logic      spi_rx_i;
   logic      spi_tx_o;
   spi_byte_t tx_byte_i;
   spi_byte_t rx_byte_o;
   logic      valid_o;

   modport slave (
      input  spi_sclk_i, spi_cs_ni, spi_rx_i, tx_byte_i,
      output spi_tx_o, rx_byte_o, valid_o
   );

   modport master (
      output spi_sclk_i, spi_cs_ni, spi_rx_i, tx_byte_i,
      input  spi_tx_o, rx_byte_o, valid_o
   );

endinterface

// File: rtl/spi_sync_edge.sv
// Pin synchronizer with optional registered rise/fall strobes.
// SPI_BYTE_SYNC_EN defined: 2-flop synchronizer; otherwise a single input register.
module spi_sync_edge #(
   parameter logic IDLE    = 1'b0,
   parameter bit   EDGE_EN = 1'b1
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic async_i,
   output logic sync_o,
   output logic rise_o,
   output logic fall_o
);

`ifdef SPI_BYTE_SYNC_EN
   logic meta_q;
   logic sync_q;

   // Two-stage synchronizer, reset to the pin's idle level.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         meta_q <= IDLE;
         sync_q <= IDLE;
      end else begin
         meta_q <= async_i;
         sync_q <= meta_q;
      end
   end
`else
   logic sync_q;

   // Single capture stage for inputs already synchronous to clk_i.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         sync_q <= IDLE;
      end else begin
         sync_q <= async_i;
      end
   end
`endif

   assign sync_o = sync_q;

   generate
      if (EDGE_EN) begin : g_edge
         logic prev_q;
         logic rise_q;
         logic fall_q;

         // Strobes are registered, so they trail the synchronized level by one cycle.
         always_ff @(posedge clk_i) begin
            if (!rst_ni) begin
               prev_q <= IDLE;
               rise_q <= 1'b0;
               fall_q <= 1'b0;
            end else begin
               prev_q <= sync_q;
               rise_q <= sync_q & ~prev_q;
               fall_q <= ~sync_q & prev_q;
            end
         end

         assign rise_o = rise_q;
         assign fall_o = fall_q;
      end else begin : g_no_edge
         assign rise_o = 1'b0;
         assign fall_o = 1'b0;
      end
   endgenerate

endmodule

// File: rtl/spi_byte_core.sv
// SPI mode-0 slave byte engine: MSB-first receive with one-cycle valid strobe, MSB-first transmit.
// Build option SPI_BYTE_SYNC_EN adds 2-flop synchronizers on SCLK, CS_N and MOSI.
module spi_byte_core
   import spi_pkg::*;
#(
   parameter int BITS = SPI_BITS
) (
   input  logic            clk_sys_i,
   input  logic            rst_ni,
   spi_byte_core_if.slave  bus
);

   localparam spi_bit_cnt_t LAST_BIT = spi_bit_cnt_t'(BITS - 1);

   logic sclk_sync_s;
   logic sclk_rise_s;
   logic sclk_fall_s;
   logic cs_n_s;
   logic cs_rise_s;
   logic cs_fall_s;
   logic mosi_s;
   logic mosi_rise_s;
   logic mosi_fall_s;
   logic unused_edges_s;

   spi_sync_edge #(.IDLE(1'b0), .EDGE_EN(1'b1)) u_sclk (
      .clk_i   (clk_sys_i),
      .rst_ni  (rst_ni),
      .async_i (bus.spi_sclk_i),
      .sync_o  (sclk_sync_s),
      .rise_o  (sclk_rise_s),
      .fall_o  (sclk_fall_s)
   );

   spi_sync_edge #(.IDLE(1'b1), .EDGE_EN(1'b0)) u_cs (
      .clk_i   (clk_sys_i),
      .rst_ni  (rst_ni),
      .async_i (bus.spi_cs_ni),
      .sync_o  (cs_n_s),
      .rise_o  (cs_rise_s),
      .fall_o  (cs_fall_s)
   );

   spi_sync_edge #(.IDLE(1'b0), .EDGE_EN(1'b0)) u_mosi (
      .clk_i   (clk_sys_i),
      .rst_ni  (rst_ni),
      .async_i (bus.spi_rx_i),
      .sync_o  (mosi_s),
      .rise_o  (mosi_rise_s),
      .fall_o  (mosi_fall_s)
   );

   assign unused_edges_s = ^{sclk_sync_s, cs_rise_s, cs_fall_s, mosi_rise_s, mosi_fall_s};

   spi_bit_cnt_t cnt_q,      cnt_d;
   spi_byte_t    rx_shift_q, rx_shift_d;
   spi_byte_t    rx_byte_q,  rx_byte_d;
   spi_byte_t    tx_shift_q, tx_shift_d;
   logic         valid_q,    valid_d;
   spi_byte_t    rx_next_s;

   // Byte engine next state; deasserted CS_N takes priority over any SCLK strobe.
   always_comb begin
      cnt_d      = cnt_q;
      rx_shift_d = rx_shift_q;
      rx_byte_d  = rx_byte_q;
      tx_shift_d = tx_shift_q;
      valid_d    = 1'b0;
      rx_next_s  = spi_shift_in(rx_shift_q, mosi_s);

      if (cs_n_s) begin
         cnt_d      = spi_bit_cnt_t'(0);
         tx_shift_d = bus.tx_byte_i;
      end else if (sclk_rise_s) begin
         rx_shift_d = rx_next_s;
         if (cnt_q == LAST_BIT) begin
            cnt_d     = spi_bit_cnt_t'(0);
            rx_byte_d = rx_next_s;
            valid_d   = 1'b1;
         end else begin
            cnt_d = cnt_q + spi_bit_cnt_t'(1);
         end
      end else if (sclk_fall_s) begin
         // Counter at zero marks a byte boundary: fetch the next byte instead of shifting.
         if (cnt_q != spi_bit_cnt_t'(0)) begin
            tx_shift_d = {tx_shift_q[6:0], 1'b0};
         end else begin
            tx_shift_d = bus.tx_byte_i;
         end
      end else begin
         tx_shift_d = tx_shift_q;
      end
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk_sys_i) begin
      if (!rst_ni) begin
         cnt_q      <= spi_bit_cnt_t'(0);
         rx_shift_q <= 8'h00;
         rx_byte_q  <= 8'h00;
         tx_shift_q <= 8'h00;
         valid_q    <= 1'b0;
      end else begin
         cnt_q      <= cnt_d;
         rx_shift_q <= rx_shift_d;
         rx_byte_q  <= rx_byte_d;
         tx_shift_q <= tx_shift_d;
         valid_q    <= valid_d;
      end
   end

   assign bus.spi_tx_o  = tx_shift_q[7];
   assign bus.rx_byte_o = rx_byte_q;
   assign bus.valid_o   = valid_q;

endmodule

// File: tb/tb_spi_byte_core.sv
// Directed self-checking bench for spi_byte_core (works with or without SPI_BYTE_SYNC_EN).
module tb_spi_byte_core;

   localparam int HALF = 8;

   logic        clk = 1'b0;
   logic        rst_n;
   int          n_checks = 0;
   int          n_fail = 0;
   int          bad_cnt = 0;
   int          base;
   logic        valid_prev_q = 1'b0;
   logic [7:0]  vq[$];
   logic [7:0]  miso_a;
   logic [7:0]  miso_b;

   spi_byte_core_if bus_if ();

   spi_byte_core #(.BITS(8)) dut (
      .clk_sys_i (clk),
      .rst_ni    (rst_n),
      .bus       (bus_if)
   );

   always #5 clk = ~clk;

   // Record every valid pulse; flag pulses longer than one cycle or outside SCLK high.
   always @(negedge clk) begin
      valid_prev_q <= bus_if.valid_o;
      if (bus_if.valid_o === 1'b1) begin
         vq.push_back(bus_if.rx_byte_o);
         if (bus_if.spi_sclk_i !== 1'b1 || valid_prev_q === 1'b1) bad_cnt <= bad_cnt + 1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic cs_low();
      bus_if.spi_cs_ni = 1'b0;
      #1;
      chk("valid_at_cs_fall", {31'd0, bus_if.valid_o}, 32'd0);
      cyc(3);
      chk("valid_3cyc_after_cs_fall", {31'd0, bus_if.valid_o}, 32'd0);
   endtask

   task automatic cs_high();
      bus_if.spi_cs_ni = 1'b1;
      cyc(HALF);
   endtask

   // Clock nbits MSB-first; MISO sampled just before each rising edge.
   task automatic xfer(input logic [7:0] mosi, input logic [7:0] tx_next, input int nbits,
                       output logic [7:0] miso);
      miso = 8'h00;
      for (int i = 7; i >= 8 - nbits; i--) begin
         bus_if.spi_rx_i = mosi[i];
         cyc(HALF);
         miso[i] = bus_if.spi_tx_o;
         bus_if.spi_sclk_i = 1'b1;
         if (i == 0) bus_if.tx_byte_i = tx_next;
         cyc(HALF);
         bus_if.spi_sclk_i = 1'b0;
      end
   endtask

   initial begin
      rst_n = 1'b0;
      bus_if.spi_sclk_i = 1'b0;
      bus_if.spi_cs_ni  = 1'b1;
      bus_if.spi_rx_i   = 1'b0;
      bus_if.tx_byte_i  = 8'h00;
      cyc(4);
      chk("rst_valid", {31'd0, bus_if.valid_o}, 32'd0);
      chk("rst_rx_byte", {24'd0, bus_if.rx_byte_o}, 32'h00);
      chk("rst_tx", {31'd0, bus_if.spi_tx_o}, 32'd0);
      rst_n = 1'b1;
      cyc(4);
      chk("post_rst_valid", {31'd0, bus_if.valid_o}, 32'd0);
      chk("post_rst_rx_byte", {24'd0, bus_if.rx_byte_o}, 32'h00);
      chk("post_rst_tx", {31'd0, bus_if.spi_tx_o}, 32'd0);

      // Single byte 0xDA
      bus_if.tx_byte_i = 8'hDA;
      cyc(4);
      base = vq.size();
      cs_low();
      xfer(8'hDA, 8'hDA, 8, miso_a);
      cs_high();
      chk("da_miso", {24'd0, miso_a}, 32'hDA);
      chk("da_valid_count", vq.size() - base, 32'd1);
      chk("da_valid_byte", {24'd0, vq[vq.size()-1]}, 32'hDA);
      chk("da_rx_byte", {24'd0, bus_if.rx_byte_o}, 32'hDA);

      // Single byte 0x5B
      bus_if.tx_byte_i = 8'h5B;
      cyc(4);
      base = vq.size();
      cs_low();
      xfer(8'h5B, 8'h5B, 8, miso_a);
      cs_high();
      chk("5b_miso", {24'd0, miso_a}, 32'h5B);
      chk("5b_valid_count", vq.size() - base, 32'd1);
      chk("5b_valid_byte", {24'd0, vq[vq.size()-1]}, 32'h5B);
      chk("5b_rx_byte", {24'd0, bus_if.rx_byte_o}, 32'h5B);

      // Back-to-back 0xDA then 0x5B within one CS_N low period
      bus_if.tx_byte_i = 8'hDA;
      cyc(4);
      base = vq.size();
      cs_low();
      xfer(8'hDA, 8'h5B, 8, miso_a);
      xfer(8'h5B, 8'h5B, 8, miso_b);
      cs_high();
      chk("b2b_miso0", {24'd0, miso_a}, 32'hDA);
      chk("b2b_miso1", {24'd0, miso_b}, 32'h5B);
      chk("b2b_valid_count", vq.size() - base, 32'd2);
      chk("b2b_byte0", {24'd0, vq[base]}, 32'hDA);
      chk("b2b_byte1", {24'd0, vq[vq.size()-1]}, 32'h5B);

      // Aborted partial bytes: n = 0..7 bits, no valid, rx_byte_o holds 0x5B
      for (int n = 0; n < 8; n++) begin
         base = vq.size();
         cs_low();
         xfer(8'h3C, 8'h5B, n, miso_a);
         cs_high();
         chk($sformatf("abort%0d_valid_count", n), vq.size() - base, 32'd0);
         chk($sformatf("abort%0d_rx_byte", n), {24'd0, bus_if.rx_byte_o}, 32'h5B);
      end
      bus_if.tx_byte_i = 8'hDA;
      cyc(4);
      base = vq.size();
      cs_low();
      xfer(8'hDA, 8'hDA, 8, miso_a);
      cs_high();
      chk("post_abort_valid_count", vq.size() - base, 32'd1);
      chk("post_abort_rx_byte", {24'd0, bus_if.rx_byte_o}, 32'hDA);
      chk("post_abort_miso", {24'd0, miso_a}, 32'hDA);

      // Reset asserted mid-byte
      bus_if.tx_byte_i = 8'hFF;
      cyc(4);
      cs_low();
      xfer(8'hA5, 8'hFF, 4, miso_a);
      cyc(HALF);
      chk("pre_rst_tx", {31'd0, bus_if.spi_tx_o}, 32'd1);
      rst_n = 1'b0;
      cyc(2);
      chk("midrst_valid", {31'd0, bus_if.valid_o}, 32'd0);
      chk("midrst_rx_byte", {24'd0, bus_if.rx_byte_o}, 32'h00);
      chk("midrst_tx", {31'd0, bus_if.spi_tx_o}, 32'd0);
      rst_n = 1'b1;
      cs_high();
      bus_if.tx_byte_i = 8'h5B;
      cyc(4);
      base = vq.size();
      cs_low();
      xfer(8'h5B, 8'h5B, 8, miso_a);
      cs_high();
      chk("post_rst_xfer_valid_count", vq.size() - base, 32'd1);
      chk("post_rst_xfer_rx_byte", {24'd0, bus_if.rx_byte_o}, 32'h5B);
      chk("post_rst_xfer_miso", {24'd0, miso_a}, 32'h5B);

      cyc(2);
      chk("valid_pulse_shape", bad_cnt, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
